// File: rtl/rot_pkg.sv
// Shared definitions for the sequential rotate units: FSM state encoding
// and the default data width.
package rot_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } rot_state_e;

  localparam int DEFAULT_WIDTH = 32;

endpackage : rot_pkg

// File: rtl/rotl_stage.sv
// One conditional rotate-left stage: rotates by 2^idx when en is high,
// otherwise passes the word through unchanged.
module rotl_stage #(
  parameter int WIDTH = 32,
  parameter int AMT_W = $clog2(WIDTH)
) (
  input  logic [WIDTH-1:0] data,
  input  logic             en,
  input  logic [AMT_W-1:0] idx,
  output logic [WIDTH-1:0] rotated
);

  logic [AMT_W-1:0]   dist_s;
  logic [2*WIDTH-1:0] dbl_s;

  // Doubling the word turns the rotate into a plain shift; the upper half holds the result.
  always_comb begin
    dist_s = AMT_W'(1'b1) << idx;
    dbl_s  = {data, data} << dist_s;
    if (en) begin
      rotated = dbl_s[2*WIDTH-1:WIDTH];
    end else begin
      rotated = data;
    end
  end

endmodule : rotl_stage

// File: rtl/rotleft_seq.sv
// Sequential rotate-left: accepts a word and amount, applies one power-of-two
// stage per cycle for AMT_W cycles, then holds the result until taken.
module rotleft_seq
  import rot_pkg::*;
#(
  parameter  int WIDTH = DEFAULT_WIDTH,
  localparam int AMT_W = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  input  logic [AMT_W-1:0] in_amt,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data
);

  localparam logic [AMT_W-1:0] K_LAST = AMT_W'(AMT_W - 1);

  rot_state_e       state_r, state_nxt_s;
  logic [WIDTH-1:0] work_r, work_nxt_s;
  logic [AMT_W-1:0] amt_r, amt_nxt_s;
  logic [AMT_W-1:0] k_r, k_nxt_s;
  logic [AMT_W-1:0] amt_sh_s;
  logic             stage_en_s;
  logic [WIDTH-1:0] stage_out_s;

  // Select amount bit k without a variable bit-select on the amount register.
  always_comb begin
    amt_sh_s   = amt_r >> k_r;
    stage_en_s = amt_sh_s[0];
  end

  rotl_stage #(
    .WIDTH (WIDTH),
    .AMT_W (AMT_W)
  ) u_stage (
    .data    (work_r),
    .en      (stage_en_s),
    .idx     (k_r),
    .rotated (stage_out_s)
  );

  // Next-state and datapath update for the IDLE/SHIFT/DONE sequence.
  always_comb begin
    state_nxt_s = state_r;
    work_nxt_s  = work_r;
    amt_nxt_s   = amt_r;
    k_nxt_s     = k_r;
    case (state_r)
      IDLE: begin
        if (in_valid) begin
          state_nxt_s = SHIFT;
          work_nxt_s  = in_data;
          amt_nxt_s   = in_amt;
          k_nxt_s     = '0;
        end else begin
          state_nxt_s = IDLE;
        end
      end
      SHIFT: begin
        work_nxt_s = stage_out_s;
        k_nxt_s    = k_r + AMT_W'(1'b1);
        if (k_r == K_LAST) begin
          state_nxt_s = DONE;
        end else begin
          state_nxt_s = SHIFT;
        end
      end
      DONE: begin
        if (out_ready) begin
          state_nxt_s = IDLE;
        end else begin
          state_nxt_s = DONE;
        end
      end
      default: begin
        state_nxt_s = IDLE;
      end
    endcase
  end

  // State and datapath registers; reset discards any request in flight.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= IDLE;
      work_r  <= '0;
      amt_r   <= '0;
      k_r     <= '0;
    end else begin
      state_r <= state_nxt_s;
      work_r  <= work_nxt_s;
      amt_r   <= amt_nxt_s;
      k_r     <= k_nxt_s;
    end
  end

  assign in_ready  = (state_r == IDLE);
  assign out_valid = (state_r == DONE);
  assign out_data  = work_r;

endmodule : rotleft_seq

// File: tb/tb_rotleft_seq.sv
// Randomized self-checking bench for rotleft_seq against a bit-placement
// reference model, with directed latency, backpressure and reset cases.
module tb_rotleft_seq;

  localparam int W  = 32;
  localparam int AW = 5;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          in_valid = 1'b0;
  logic          out_ready = 1'b0;
  logic [W-1:0]  in_data = '0;
  logic [AW-1:0] in_amt = '0;
  logic          in_ready;
  logic          out_valid;
  logic [W-1:0]  out_data;

  int n_checks = 0;
  int n_fail   = 0;

  rotleft_seq #(.WIDTH(W)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .in_amt    (in_amt),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Bit i of d lands at bit (i + a) mod W.
  function automatic logic [W-1:0] ref_rotl(input logic [W-1:0] d, input int a);
    logic [W-1:0] r;
    r = '0;
    for (int i = 0; i < W; i++) r[(i + a) % W] = d[i];
    return r;
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic start_req(input logic [W-1:0] d, input logic [AW-1:0] a, input string tag);
    int cyc;
    cyc = 0;
    while (!in_ready && cyc < 20) begin
      step();
      cyc++;
    end
    chk({tag, " ready"}, 64'(in_ready), 64'(1));
    in_valid = 1'b1;
    in_data  = d;
    in_amt   = a;
    step();
    in_valid = 1'($urandom_range(0, 1));
    in_data  = W'($urandom);
    in_amt   = AW'($urandom_range(0, 31));
    chk({tag, " busy"}, 64'(in_ready), 64'(0));
  endtask

  task automatic wait_res(input logic [W-1:0] exp, input string tag);
    int cyc;
    cyc = 0;
    while (!out_valid && cyc < 20) begin
      out_ready = 1'($urandom_range(0, 1));
      in_valid  = 1'($urandom_range(0, 1));
      in_data   = W'($urandom);
      step();
      cyc++;
    end
    out_ready = 1'b0;
    in_valid  = 1'b0;
    chk({tag, " latency"}, 64'(cyc), 64'(AW));
    chk({tag, " data"}, 64'(out_data), 64'(exp));
  endtask

  task automatic hold_res(input logic [W-1:0] exp, input int hold, input string tag);
    for (int h = 0; h < hold; h++) begin
      in_valid = 1'($urandom_range(0, 1));
      in_data  = W'($urandom);
      step();
      chk({tag, " hold data"}, 64'(out_data), 64'(exp));
      chk({tag, " hold valid"}, 64'(out_valid), 64'(1));
      chk({tag, " hold ready"}, 64'(in_ready), 64'(0));
    end
    in_valid = 1'b0;
  endtask

  task automatic release_res(input string tag);
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
    chk({tag, " released"}, 64'(out_valid), 64'(0));
    chk({tag, " idle"}, 64'(in_ready), 64'(1));
  endtask

  task automatic full_req(input logic [W-1:0] d, input logic [AW-1:0] a, input int hold, input string tag);
    logic [W-1:0] exp;
    exp = ref_rotl(d, int'(a));
    start_req(d, a, tag);
    wait_res(exp, tag);
    hold_res(exp, hold, tag);
    release_res(tag);
  endtask

  initial begin
    logic [W-1:0] d;
    #1;
    chk("rst in_ready", 64'(in_ready), 64'(1));
    chk("rst out_valid", 64'(out_valid), 64'(0));
    chk("rst out_data", 64'(out_data), 64'(0));
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;

    full_req(32'h0000_0001, 5'd22, 0, "one_amt22");
    chk("one_amt22 ref", 64'(ref_rotl(32'h0000_0001, 22)), 64'h0040_0000);
    full_req(32'h8000_0000, 5'd1, 1, "msb_amt1");
    full_req(32'hA5A5_A5A5, 5'd0, 0, "amt0");
    full_req(32'hD159_E048, 5'd22, 2, "roundtrip");

    for (int a = 0; a < 32; a++) begin
      d = W'($urandom);
      full_req(d, AW'(a), int'($urandom_range(0, 2)), $sformatf("sweep%0d", a));
    end

    // Backpressure, then a second request held across the output handshake.
    start_req(32'h1234_5678, 5'd4, "bp1");
    wait_res(32'h2345_6781, "bp1");
    hold_res(32'h2345_6781, 3, "bp1");
    in_valid  = 1'b1;
    in_data   = 32'h0000_00F0;
    in_amt    = 5'd4;
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
    chk("bp no accept on release", 64'(in_ready), 64'(1));
    chk("bp released", 64'(out_valid), 64'(0));
    step();
    in_valid = 1'b0;
    chk("bp2 accepted", 64'(in_ready), 64'(0));
    wait_res(32'h0000_0F00, "bp2");
    release_res("bp2");

    // Reset in the middle of SHIFT discards the request.
    start_req(32'hCAFE_BABE, 5'd7, "rst_mid");
    step();
    step();
    step();
    #2;
    rst_n = 1'b0;
    #1;
    chk("rst_mid out_valid", 64'(out_valid), 64'(0));
    chk("rst_mid in_ready", 64'(in_ready), 64'(1));
    chk("rst_mid out_data", 64'(out_data), 64'(0));
    in_valid = 1'b1;
    step();
    in_valid = 1'b0;
    chk("rst_mid held", 64'(out_valid), 64'(0));
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 8; i++) begin
      step();
      chk("rst_mid no result", 64'(out_valid), 64'(0));
    end
    full_req(32'h0000_FFFF, 5'd16, 0, "after_rst");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation time limit reached");
    $fatal(1, "timeout");
  end

endmodule : tb_rotleft_seq
